mac_fifo_reader: RTL and testbench

MAC_FIFO_READER -- requirements
Module: mac_fifo_reader

---
 rtl/mac_fifo_reader_if.sv | 27 ++
 rtl/mac_fifo_reader.sv | 111 +++++++++++
 tb/tb_mac_fifo_reader.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mac_fifo_reader_if.sv
// Handshake bundle between mac_fifo_reader and its two operand FIFOs plus controller.
// The slave side is the MAC reader; the master side drives start, FIFO flags and data.
interface mac_fifo_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24
);
  logic                  start;
  logic                  a_empty;
  logic                  b_empty;
  logic [DATA_WIDTH-1:0] a_data;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  a_rden;
  logic                  b_rden;
  logic                  busy;
  logic                  done;
  logic [ACC_WIDTH-1:0]  result;

  modport master (
    output start, a_empty, b_empty, a_data, b_data,
    input  a_rden, b_rden, busy, done, result
  );

  modport slave (
    input  start, a_empty, b_empty, a_data, b_data,
    output a_rden, b_rden, busy, done, result
  );
endinterface

// File: rtl/mac_fifo_reader.sv
// Reads LEN operand pairs from two FIFOs and accumulates their unsigned dot product.
// Optional macro MAC_FIFO_READER_SATURATE_EN clamps the accumulator instead of wrapping.
module mac_fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN        = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic             clk,
  input  logic             rst,
  mac_fifo_reader_if.slave bus
);

  localparam int CNT_W  = $clog2(LEN + 1);
  localparam int PROD_W = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] r_result;
  logic [CNT_W-1:0]     r_rd_cnt;
  logic                 r_pend;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_rden;
  logic [PROD_W-1:0]    w_prod;
  logic [ACC_WIDTH-1:0] w_prod_ext;
  logic [ACC_WIDTH-1:0] w_sum;
  logic [ACC_WIDTH-1:0] w_acc_next;

  // Both FIFOs are popped together and only when both hold a word; reset gates the strobe.
  assign w_rden = (r_state == S_READ) && !bus.a_empty && !bus.b_empty &&
                  (r_rd_cnt < CNT_W'(LEN)) && !rst;

  assign w_prod     = PROD_W'(bus.a_data) * PROD_W'(bus.b_data);
  assign w_prod_ext = ACC_WIDTH'(w_prod);

`ifdef MAC_FIFO_READER_SATURATE_EN
  logic [ACC_WIDTH:0] w_sum_ext;
  assign w_sum_ext = {1'b0, r_acc} + {1'b0, w_prod_ext};
  assign w_sum     = w_sum_ext[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_sum_ext[ACC_WIDTH-1:0];
`else
  assign w_sum = r_acc + w_prod_ext;
`endif

  // Data for a read arrives one cycle later, so only that cycle contributes a product.
  assign w_acc_next = r_pend ? w_sum : r_acc;

  assign bus.a_rden = w_rden;
  assign bus.b_rden = w_rden;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

  // Control FSM, read counter, accumulator and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_acc    <= {ACC_WIDTH{1'b0}};
      r_result <= {ACC_WIDTH{1'b0}};
      r_rd_cnt <= {CNT_W{1'b0}};
      r_pend   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_pend <= w_rden;
      r_done <= 1'b0;
      r_acc  <= w_acc_next;
      if (w_rden) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (bus.start) begin
            r_state  <= S_READ;
            r_busy   <= 1'b1;
            r_acc    <= {ACC_WIDTH{1'b0}};
            r_rd_cnt <= {CNT_W{1'b0}};
          end
        end
        S_READ: begin
          if (w_rden && (r_rd_cnt == CNT_W'(LEN - 1))) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Final pair lands here; publish the complete sum only now.
          r_state  <= S_DONE;
          r_done   <= 1'b1;
          r_result <= w_acc_next;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_fifo_reader.sv
// Directed, table-driven bench for mac_fifo_reader with a behavioural dual-FIFO model.
module tb_mac_fifo_reader;
  localparam int DW   = 8;
  localparam int LEN  = 8;
  localparam int AW   = 24;
  localparam int AW16 = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_fifo_reader_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) ifc ();
  mac_fifo_reader #(.DATA_WIDTH(DW), .LEN(LEN), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .bus(ifc)
  );

  mac_fifo_reader_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW16)) ifc16 ();
  mac_fifo_reader #(.DATA_WIDTH(DW), .LEN(LEN), .ACC_WIDTH(AW16)) dut16 (
    .clk(clk), .rst(rst), .bus(ifc16)
  );

  // 16-bit instance sees an endless stream of 255 operands.
  assign ifc16.a_empty = 1'b0;
  assign ifc16.b_empty = 1'b0;
  assign ifc16.a_data  = 8'd255;
  assign ifc16.b_data  = 8'd255;

  // Shared-pointer FIFO model; data is registered one cycle after rden.
  logic [DW-1:0] mem_a [0:63];
  logic [DW-1:0] mem_b [0:63];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic stall_a = 1'b0;
  logic stall_b = 1'b0;
  logic flush   = 1'b0;

  assign ifc.a_empty = (rd_ptr >= wr_ptr) || stall_a;
  assign ifc.b_empty = (rd_ptr >= wr_ptr) || stall_b;

  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (ifc.a_rden || ifc.b_rden) begin
      ifc.a_data <= mem_a[rd_ptr[5:0]];
      ifc.b_data <= mem_b[rd_ptr[5:0]];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic load(input logic [63:0] a_pk, input logic [63:0] b_pk);
    for (int i = 0; i < LEN; i++) begin
      mem_a[wr_ptr[5:0]] = a_pk[8*i +: 8];
      mem_b[wr_ptr[5:0]] = b_pk[8*i +: 8];
      wr_ptr = wr_ptr + 1;
    end
  endtask

  // Cycle c is the clock period in which start bit c is presented; sampled at negedge+1.
  task automatic run_op(input logic [63:0] st_mask, input logic [63:0] sa_mask,
                        input logic [63:0] sb_mask, input int ncyc,
                        output int first_done, output int last_done, output int n_done,
                        output int n_rden, output int viol, output int partial);
    logic [AW-1:0] prev_res;
    first_done = -1; last_done = -1; n_done = 0; n_rden = 0; viol = 0; partial = 0;
    prev_res = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      ifc.start = st_mask[c];
      stall_a   = sa_mask[c];
      stall_b   = sb_mask[c];
      #1;
      if (ifc.a_rden !== ifc.b_rden) viol++;
      if (ifc.a_rden && ifc.a_empty) viol++;
      if (ifc.b_rden && ifc.b_empty) viol++;
      if (ifc.a_rden) n_rden++;
      if (ifc.done) begin
        n_done++;
        if (first_done < 0) first_done = c;
        last_done = c;
      end else if (c > 0 && ifc.result !== prev_res) begin
        partial++;
      end
      prev_res = ifc.result;
    end
    @(negedge clk);
    ifc.start = 1'b0;
    stall_a   = 1'b0;
    stall_b   = 1'b0;
  endtask

  typedef struct {
    logic [63:0]   a_pk;
    logic [63:0]   b_pk;
    logic [63:0]   sa;
    logic [63:0]   sb;
    logic [AW-1:0] exp_res;
    int            exp_done;
  } vec_t;

  vec_t vecs [6];
  int fd, ld, nd, nr, vi, pa;
  logic [AW16-1:0] exp16;
  int done16_cyc;

  initial begin
    // Operand element i sits at bits [8i+7:8i].
    vecs[0] = '{64'h0807060504030201, 64'h0807060504030201, 64'h0,  64'h0,  24'd204,    10};
    vecs[1] = '{64'h0807060504030201, 64'h0807060504030201, 64'h38, 64'h0,  24'd204,    13};
    vecs[2] = '{64'h0000000000000000, 64'h0807060504030201, 64'h0,  64'h0,  24'd0,      10};
    vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h0,  64'h0,  24'd520200, 10};
    vecs[4] = '{64'h0807060504030201, 64'h0202020202020202, 64'h0,  64'h06, 24'd72,     12};
    vecs[5] = '{64'h50463C32281E140A, 64'h0102030405060708, 64'h0,  64'h0,  24'd1200,   10};

    rst         = 1'b1;
    ifc.start   = 1'b0;
    ifc16.start = 1'b0;
    load(64'h0807060504030201, 64'h0807060504030201);
    repeat (3) @(negedge clk);
    #1;
    chk("rst rden",   {63'd0, ifc.a_rden | ifc.b_rden}, 64'd0);
    chk("rst busy",   {63'd0, ifc.busy}, 64'd0);
    chk("rst done",   {63'd0, ifc.done}, 64'd0);
    chk("rst result", 64'(ifc.result), 64'd0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      if (v > 0) load(vecs[v].a_pk, vecs[v].b_pk);
      run_op(64'h1, vecs[v].sa, vecs[v].sb, 30, fd, ld, nd, nr, vi, pa);
      chk($sformatf("v%0d result", v),     64'(ifc.result), 64'(vecs[v].exp_res));
      chk($sformatf("v%0d done_cycle", v), 64'(fd), 64'(vecs[v].exp_done));
      chk($sformatf("v%0d done_count", v), 64'(nd), 64'd1);
      chk($sformatf("v%0d rden_count", v), 64'(nr), 64'(LEN));
      chk($sformatf("v%0d rden_rule", v),  64'(vi), 64'd0);
      chk($sformatf("v%0d partial", v),    64'(pa), 64'd0);
    end

    // Reset four cycles into an operation.
    load(64'h0807060504030201, 64'h0807060504030201);
    @(negedge clk); ifc.start = 1'b1;
    @(negedge clk); ifc.start = 1'b0;
    #1;
    chk("mid busy", {63'd0, ifc.busy}, 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid rst rden", {63'd0, ifc.a_rden | ifc.b_rden}, 64'd0);
    @(negedge clk);
    #1;
    chk("mid rst busy",   {63'd0, ifc.busy}, 64'd0);
    chk("mid rst result", 64'(ifc.result), 64'd0);
    rst = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    run_op(64'h0, 64'h0, 64'h0, 12, fd, ld, nd, nr, vi, pa);
    chk("mid no done", 64'(nd), 64'd0);
    chk("mid no rden", 64'(nr), 64'd0);
    load(vecs[5].a_pk, vecs[5].b_pk);
    run_op(64'h1, 64'h0, 64'h0, 20, fd, ld, nd, nr, vi, pa);
    chk("rerun result", 64'(ifc.result), 64'd1200);
    chk("rerun done",   64'(fd), 64'd10);

    // start while busy (cycle 5) and in the DONE cycle (cycle 10) is ignored.
    load(64'h0807060504030201, 64'h0807060504030201);
    run_op(64'h421, 64'h0, 64'h0, 20, fd, ld, nd, nr, vi, pa);
    chk("ign done_count", 64'(nd), 64'd1);
    chk("ign done_cycle", 64'(fd), 64'd10);
    chk("ign result",     64'(ifc.result), 64'd204);
    chk("ign rden_count", 64'(nr), 64'(LEN));
    chk("ign rden_rule",  64'(vi), 64'd0);
    chk("ign busy_after", {63'd0, ifc.busy}, 64'd0);

    // start held high through cycle 11 launches a second operation at cycle 11.
    load(64'h0807060504030201, 64'h0807060504030201);
    load(64'h0202020202020202, 64'h0807060504030201);
    run_op(64'hFFF, 64'h0, 64'h0, 30, fd, ld, nd, nr, vi, pa);
    chk("b2b done_count", 64'(nd), 64'd2);
    chk("b2b first_done", 64'(fd), 64'd10);
    chk("b2b last_done",  64'(ld), 64'd21);
    chk("b2b rden_count", 64'(nr), 64'd16);
    chk("b2b result",     64'(ifc.result), 64'd72);
    chk("b2b partial",    64'(pa), 64'd0);

    // 16-bit accumulator: 8 * 255 * 255 overflows 2^16.
`ifdef MAC_FIFO_READER_SATURATE_EN
    exp16 = 16'hFFFF;
`else
    exp16 = 16'((8 * 255 * 255) % 65536);
`endif
    done16_cyc = -1;
    @(negedge clk); ifc16.start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) ifc16.start = 1'b0;
      #1;
      if (ifc16.done && done16_cyc < 0) done16_cyc = c;
    end
    chk("acc16 done_cycle", 64'(done16_cyc), 64'd10);
    chk("acc16 result",     64'(ifc16.result), 64'(exp16));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
